// File: rtl/uart_loader_pkg.sv
// Byte codes and FSM state encoding shared by the UART memory loader.
package uart_loader_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h3F;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_MEMWR  = 3'd3;
  localparam logic [2:0] ST_MEMRD  = 3'd4;
  localparam logic [2:0] ST_RDWAIT = 3'd5;
  localparam logic [2:0] ST_REPLY  = 3'd6;

  // Big-endian byte accumulation: the newest byte lands in the LSBs.
  function automatic logic [31:0] shift_in_byte(input logic [31:0] word, input logic [7:0] b);
    return {word[23:0], b};
  endfunction

endpackage

// File: rtl/uart_loader.sv
// UART-driven memory loader: 'W' addr data writes a word, 'R' addr reads one back.
// Optional idle timeout on partial packets is enabled by defining UART_LOADER_TIMEOUT_EN.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int AW      = 16,
  parameter int TIMEOUT = 50_000_000,
  parameter int TO_BIT  = 26
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_empty,
  input  logic [7:0]    r_data,
  output logic          rd_uart,
  input  logic          tx_full,
  output logic [7:0]    w_data,
  output logic          wr_uart,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  logic [2:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          is_wr_q, is_wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   rsp_q, rsp_d;
  logic          accept_s, pop_s, push_s, timeout_s;

  // Strobes are gated by reset so no byte is consumed or emitted while the FSM is being cleared.
  assign accept_s  = (state_q == ST_IDLE) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign pop_s     = accept_s && !rx_empty && !reset;
  assign push_s    = (state_q == ST_REPLY) && !tx_full && !reset;

  assign rd_uart   = pop_s;
  assign wr_uart   = push_s;
  assign w_data    = rsp_q[31:24];
  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;
  assign mem_we    = (state_q == ST_MEMWR) && !reset;
  assign mem_re    = (state_q == ST_MEMRD) && !reset;
  assign busy      = (state_q != ST_IDLE) && !reset;

`ifdef UART_LOADER_TIMEOUT_EN
  logic [TO_BIT-1:0] to_cnt_q, to_cnt_d;

  // Count consecutive pop-free cycles while a packet is partially received.
  always_comb begin
    to_cnt_d  = '0;
    timeout_s = 1'b0;
    if (((state_q == ST_ADDR) || (state_q == ST_DATA)) && !pop_s) begin
      if (to_cnt_q == TO_BIT'(TIMEOUT - 1)) begin
        timeout_s = 1'b1;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d  = to_cnt_q + TO_BIT'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_cfg_s;
  assign timeout_s    = 1'b0;
  assign unused_cfg_s = (TIMEOUT > TO_BIT);
`endif

  // Packet FSM: cnt_q holds the number of bytes still to receive or transmit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rsp_d   = rsp_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          if (r_data == CMD_WRITE) begin
            is_wr_d = 1'b1;
            cnt_d   = 3'd2;
            state_d = ST_ADDR;
          end else if (r_data == CMD_READ) begin
            is_wr_d = 1'b0;
            cnt_d   = 3'd2;
            state_d = ST_ADDR;
          end else begin
            rsp_d   = {RSP_ERR, 24'h000000};
            cnt_d   = 3'd1;
            state_d = ST_REPLY;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (timeout_s) begin
          state_d = ST_IDLE;
        end else if (pop_s) begin
          // Upper address bits fall off the top of the AW-wide register.
          addr_d = AW'({addr_q[7:0], r_data});
          if (cnt_q == 3'd1) begin
            if (is_wr_q) begin
              cnt_d   = 3'd4;
              state_d = ST_DATA;
            end else begin
              state_d = ST_MEMRD;
            end
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (timeout_s) begin
          state_d = ST_IDLE;
        end else if (pop_s) begin
          data_d = shift_in_byte(data_q, r_data);
          if (cnt_q == 3'd1) begin
            state_d = ST_MEMWR;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_MEMWR: begin
        rsp_d   = {RSP_OK, 24'h000000};
        cnt_d   = 3'd1;
        state_d = ST_REPLY;
      end
      ST_MEMRD: begin
        state_d = ST_RDWAIT;
      end
      ST_RDWAIT: begin
        rsp_d   = mem_rdata;
        cnt_d   = 3'd4;
        state_d = ST_REPLY;
      end
      ST_REPLY: begin
        if (push_s) begin
          rsp_d = shift_in_byte(rsp_q, 8'h00);
          if (cnt_q == 3'd1) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end else begin
          state_d = ST_REPLY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= 32'h00000000;
      rsp_q   <= 32'h00000000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Randomised self-checking bench for uart_loader: FIFO/memory environment plus packet-level reference model.
`timescale 1ns/1ps
module tb_uart_loader;

  localparam int AW = 12;
  localparam int MW = 1 << AW;

  logic          clk = 1'b0;
  logic          reset, rx_empty, rd_uart, tx_full, wr_uart, mem_we, mem_re, busy;
  logic [7:0]    r_data, w_data;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  uart_loader #(.AW(AW), .TIMEOUT(100), .TO_BIT(8)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy)
  );

  // environment observation logs
  logic [7:0]    rx_q[$];
  logic [7:0]    tx_log[$];
  int            tx_cyc[$];
  logic [AW-1:0] we_addr_log[$];
  logic [31:0]   we_data_log[$];
  int            re_cnt = 0, proto_viol = 0, bp_viol = 0, last_pop_cyc = 0, cyc = 0;
  logic          force_full = 1'b0;
  bit            rand_full = 1'b0;
  logic [31:0]   env_mem[MW];

  // reference model state
  logic [31:0]   ref_mem[MW];
  logic [7:0]    exp_tx[$];
  int            exp_we_addr[$];
  logic [31:0]   exp_we_data[$];
  int            exp_re;
  logic [7:0]    pkt[$];

  int n_cmp = 0, n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // UART FIFOs and memory: outputs sampled mid-cycle, inputs updated 1ns after the edge.
  initial begin : env_proc
    logic          s_rd, s_wr, s_we, s_re, s_full, s_empty;
    logic [7:0]    s_wd;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wdat;
    rx_empty  = 1'b1;
    r_data    = 8'h00;
    tx_full   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      s_rd = rd_uart; s_wr = wr_uart; s_wd = w_data; s_we = mem_we; s_re = mem_re;
      s_addr = mem_addr; s_wdat = mem_wdata; s_full = tx_full; s_empty = rx_empty;
      @(posedge clk);
      cyc++;
      #1;
      if (s_rd) begin
        if (s_empty || rx_q.size() == 0) proto_viol++;
        else void'(rx_q.pop_front());
        last_pop_cyc = cyc;
      end
      if (s_wr) begin
        if (s_full) bp_viol++;
        tx_log.push_back(s_wd);
        tx_cyc.push_back(cyc);
      end
      if (s_we) begin
        env_mem[s_addr] = s_wdat;
        we_addr_log.push_back(s_addr);
        we_data_log.push_back(s_wdat);
      end
      if (s_re) begin
        mem_rdata = env_mem[s_addr];
        re_cnt++;
      end
      rx_empty = (rx_q.size() == 0);
      r_data   = rx_empty ? 8'h00 : rx_q[0];
      tx_full  = rand_full ? ($urandom_range(0, 2) == 0) : force_full;
    end
  end

  function automatic logic [31:0] tx_at(input int i);
    return (i < tx_log.size()) ? {24'h0, tx_log[i]} : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] log_addr(input int i);
    return (i < we_addr_log.size()) ? 32'(we_addr_log[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] log_data(input int i);
    return (i < we_data_log.size()) ? we_data_log[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic int first_tx_cyc();
    return (tx_cyc.size() > 0) ? tx_cyc[0] : -1000;
  endfunction

  task automatic clear_logs();
    tx_log.delete(); tx_cyc.delete(); we_addr_log.delete(); we_data_log.delete();
    exp_tx.delete(); exp_we_addr.delete(); exp_we_data.delete();
    re_cnt = 0; exp_re = 0;
  endtask

  task automatic mk(input logic [55:0] v, input int n);
    pkt.delete();
    for (int i = n - 1; i >= 0; i--) pkt.push_back(v[i*8 +: 8]);
  endtask

  // Packet-level semantics: what the loader must reply and write for one packet.
  task automatic model_pkt();
    int          a;
    logic [31:0] d;
    case (pkt[0])
      8'h57: begin
        a = ((int'(pkt[1]) * 256) + int'(pkt[2])) % MW;
        d = (32'(pkt[3]) << 24) | (32'(pkt[4]) << 16) | (32'(pkt[5]) << 8) | 32'(pkt[6]);
        ref_mem[a] = d;
        exp_we_addr.push_back(a);
        exp_we_data.push_back(d);
        exp_tx.push_back(8'h4B);
      end
      8'h52: begin
        a = ((int'(pkt[1]) * 256) + int'(pkt[2])) % MW;
        d = ref_mem[a];
        for (int i = 3; i >= 0; i--) exp_tx.push_back(8'(d >> (8 * i)));
        exp_re++;
      end
      default: exp_tx.push_back(8'h3F);
    endcase
  endtask

  task automatic push_pkt(input bit gaps);
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
      rx_q.push_back(pkt[i]);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(rx_q.size() == 0 && rx_empty && !busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check_val({tag, "_idle"}, 32'(n < budget), 32'd1);
  endtask

  task automatic gen_random_pkt();
    int          kind;
    logic [7:0]  u;
    kind = $urandom_range(0, 9);
    pkt.delete();
    if (kind < 7) begin
      pkt.push_back((kind < 4) ? 8'h57 : 8'h52);
      pkt.push_back(8'($urandom_range(0, 255)));
      pkt.push_back(8'($urandom_range(0, 255)));
      if (kind < 4) for (int i = 0; i < 4; i++) pkt.push_back(8'($urandom_range(0, 255)));
    end else begin
      u = 8'($urandom_range(0, 255));
      if (u == 8'h57 || u == 8'h52) u = 8'h41;
      pkt.push_back(u);
    end
  endtask

  task automatic compare_model(input string tag);
    check_val({tag, "_tx_cnt"}, 32'(tx_log.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size(); i++) check_val({tag, "_tx"}, tx_at(i), {24'h0, exp_tx[i]});
    check_val({tag, "_we_cnt"}, 32'(we_addr_log.size()), 32'(exp_we_addr.size()));
    for (int i = 0; i < exp_we_addr.size(); i++) begin
      check_val({tag, "_we_addr"}, log_addr(i), 32'(exp_we_addr[i]));
      check_val({tag, "_we_data"}, log_data(i), exp_we_data[i]);
    end
    check_val({tag, "_re_cnt"}, 32'(re_cnt), 32'(exp_re));
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main_proc
    int n, hold, diff;
    reset = 1'b1;
    for (int i = 0; i < MW; i++) begin
      env_mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'hA5A50000;
      ref_mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'hA5A50000;
    end
    clear_logs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_rd", 32'(rd_uart), 32'd0);
    check_val("rst_wr", 32'(wr_uart), 32'd0);
    check_val("rst_wdata", 32'(w_data), 32'd0);
    check_val("rst_we", 32'(mem_we), 32'd0);
    check_val("rst_re", 32'(mem_re), 32'd0);
    check_val("rst_addr", 32'(mem_addr), 32'd0);
    check_val("rst_mwdata", mem_wdata, 32'd0);

    // directed write
    clear_logs();
    mk(56'h57_0010_DEADBEEF, 7); model_pkt(); push_pkt(1'b0);
    wait_idle(300, "w");
    check_val("w_we_cnt", 32'(we_addr_log.size()), 32'd1);
    check_val("w_addr", log_addr(0), 32'h0000_0010);
    check_val("w_data", log_data(0), 32'hDEAD_BEEF);
    check_val("w_tx_cnt", 32'(tx_log.size()), 32'd1);
    check_val("w_tx0", tx_at(0), 32'h4B);
    check_val("w_lat", 32'(first_tx_cyc() - last_pop_cyc), 32'd2);
    check_val("w_re_cnt", 32'(re_cnt), 32'd0);

    // directed read
    clear_logs();
    env_mem[16] = 32'h1234_5678;
    ref_mem[16] = 32'h1234_5678;
    mk(56'h52_0010, 3); model_pkt(); push_pkt(1'b0);
    wait_idle(300, "r");
    check_val("r_re_cnt", 32'(re_cnt), 32'd1);
    check_val("r_we_cnt", 32'(we_addr_log.size()), 32'd0);
    check_val("r_tx_cnt", 32'(tx_log.size()), 32'd4);
    check_val("r_tx0", tx_at(0), 32'h12);
    check_val("r_tx1", tx_at(1), 32'h34);
    check_val("r_tx2", tx_at(2), 32'h56);
    check_val("r_tx3", tx_at(3), 32'h78);
    check_val("r_lat", 32'(first_tx_cyc() - last_pop_cyc), 32'd3);

    // unknown command
    clear_logs();
    mk(56'h41, 1); model_pkt(); push_pkt(1'b0);
    wait_idle(300, "u");
    check_val("u_tx_cnt", 32'(tx_log.size()), 32'd1);
    check_val("u_tx0", tx_at(0), 32'h3F);
    check_val("u_lat", 32'(first_tx_cyc() - last_pop_cyc), 32'd1);
    check_val("u_we_cnt", 32'(we_addr_log.size()), 32'd0);
    check_val("u_re_cnt", 32'(re_cnt), 32'd0);
    check_val("u_busy", 32'(busy), 32'd0);

    // backpressure during a read reply
    clear_logs();
    bp_viol = 0;
    mk(56'h52_0010, 3); model_pkt(); push_pkt(1'b0);
    n = 0;
    while (tx_log.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("bp_start", 32'(n < 200), 32'd1);
    force_full = 1'b1;
    repeat (2) @(negedge clk);
    hold = tx_log.size();
    check_val("bp_mid", 32'(hold < 4), 32'd1);
    repeat (20) @(negedge clk);
    check_val("bp_hold", 32'(tx_log.size()), 32'(hold));
    force_full = 1'b0;
    wait_idle(300, "bp");
    compare_model("bp");
    check_val("bp_viol", 32'(bp_viol), 32'd0);

    // randomised packet stream with random tx backpressure
    clear_logs();
    rand_full = 1'b1;
    for (int k = 0; k < 40; k++) begin
      gen_random_pkt();
      model_pkt();
      push_pkt(1'b1);
    end
    wait_idle(8000, "rnd");
    rand_full = 1'b0;
    compare_model("rnd");
    check_val("rnd_bp_viol", 32'(bp_viol), 32'd0);
    check_val("rnd_pop_viol", 32'(proto_viol), 32'd0);
    diff = 0;
    for (int i = 0; i < MW; i++) if (env_mem[i] !== ref_mem[i]) diff++;
    check_val("rnd_mem_diff", 32'(diff), 32'd0);

`ifdef UART_LOADER_TIMEOUT_EN
    // abandoned partial packet
    clear_logs();
    mk(56'h57_00, 2); push_pkt(1'b0);
    repeat (110) @(negedge clk);
    check_val("to_busy", 32'(busy), 32'd0);
    check_val("to_tx_cnt", 32'(tx_log.size()), 32'd0);
    check_val("to_we_cnt", 32'(we_addr_log.size()), 32'd0);
    mk(56'h52_0010, 3); model_pkt(); push_pkt(1'b0);
    wait_idle(300, "to");
    compare_model("to");
`endif

    // reset in the middle of a write packet
    clear_logs();
    mk(56'h57_0010_DE, 4); push_pkt(1'b0);
    n = 0;
    while (rx_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_val("rm_busy_pre", 32'(busy), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("rm_busy", 32'(busy), 32'd0);
    check_val("rm_rd", 32'(rd_uart), 32'd0);
    check_val("rm_wr", 32'(wr_uart), 32'd0);
    check_val("rm_wdata", 32'(w_data), 32'd0);
    check_val("rm_we", 32'(mem_we), 32'd0);
    check_val("rm_re", 32'(mem_re), 32'd0);
    check_val("rm_addr", 32'(mem_addr), 32'd0);
    check_val("rm_mwdata", mem_wdata, 32'd0);
    mk(56'h57_0123_CAFEBABE, 7); model_pkt(); push_pkt(1'b0);
    wait_idle(300, "rm");
    compare_model("rm");
    check_val("rm_addr_post", log_addr(0), 32'h0000_0123);
    check_val("rm_data_post", log_data(0), 32'hCAFE_BABE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
